// File: rtl/qspi_resp_pkg.sv
// Shared types and constants for the QSPI flash responder.
package qspi_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_MODE   = 3'd3,
        ST_DUMMY  = 3'd4,
        ST_DATA   = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_QIOR  = 8'hEB;
    localparam logic [1:0] MODE_CONT = 2'b10;

    // Continuous-read is requested by mode bits M[5:4] only.
    function automatic logic mode_is_cont(input logic [1:0] m54);
        return (m54 == MODE_CONT);
    endfunction

endpackage

// File: rtl/qspi_resp_sync.sv
// Synchronizes the host-side flash pins into HCLK and detects SCK edges.
module qspi_resp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck_i,
    input  logic       cen_i,
    input  logic [3:0] sio_i,
    output logic       sck_rise_s,
    output logic       sck_fall_s,
    output logic       cen_s,
    output logic [3:0] sio_s
);

    // Packed as {sck, cen, sio[3:0]}; chip enable idles deasserted (high).
    localparam logic [5:0] SYNC_RST = 6'b01_0000;

    logic [5:0] sync_r [SYNC_STAGES];
    logic       sck_prev_r;

    // Synchronizer chain plus previous synced SCK sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= SYNC_RST;
            end
            sck_prev_r <= 1'b0;
        end else begin
            sync_r[0] <= {sck_i, cen_i, sio_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            sck_prev_r <= sync_r[SYNC_STAGES-1][5];
        end
    end

    assign sck_rise_s = sync_r[SYNC_STAGES-1][5] & ~sck_prev_r;
    assign sck_fall_s = ~sync_r[SYNC_STAGES-1][5] & sck_prev_r;
    assign cen_s      = sync_r[SYNC_STAGES-1][4];
    assign sio_s      = sync_r[SYNC_STAGES-1][3:0];

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI NOR-flash responder: decodes READ (03h) and Quad I/O Fast Read (EBh,
// with continuous-read mode) and serves bytes from a synchronous memory port.
module qspi_flash_responder
    import qspi_resp_pkg::*;
#(
    parameter int MEM_AW      = 20,
    parameter int DUMMY_CYC   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              SCK_I,
    input  logic              CEN_I,
    input  logic [3:0]        SIO_I,
    output logic [3:0]        SIO_O,
    output logic [3:0]        SIO_OE,
    output logic              MEMCS,
    output logic [MEM_AW-1:0] MEMADDR,
    input  logic [7:0]        MEMRDATA
);

    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYC - 1);

    logic        sck_rise_s;
    logic        sck_fall_s;
    logic        cen_s;
    logic [3:0]  sio_s;

    state_t      state_r;
    logic        quad_r;       // current transaction uses quad address/data
    logic        cont_mode_r;  // next CEN-low skips the command byte
    logic [4:0]  cnt_r;        // bit / nibble / cycle counter within a phase
    logic [6:0]  cmd_r;
    logic [1:0]  mode_hi_r;    // M[5:4], captured from the first mode nibble
    logic [23:0] addr_r;       // address of the byte currently in shift_r
    logic [7:0]  shift_r;
    logic [7:0]  pbuf_r;       // prefetched next byte
    logic        rd_seen_r;    // memory saw MEMCS last edge; data valid now
    logic        rd_tgt_r;     // 0: returning data goes to shift_r, 1: to pbuf_r

    logic [7:0]  cmd_next_s;
    logic [23:0] addr_next_s;
    logic [23:0] addr_inc1_s;
    logic [23:0] addr_inc2_s;
    logic        addr_last_s;
    logic        data_last_s;

    qspi_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .sck_i      (SCK_I),
        .cen_i      (CEN_I),
        .sio_i      (SIO_I),
        .sck_rise_s (sck_rise_s),
        .sck_fall_s (sck_fall_s),
        .cen_s      (cen_s),
        .sio_s      (sio_s)
    );

    assign cmd_next_s  = {cmd_r, sio_s[0]};
    assign addr_next_s = quad_r ? {addr_r[19:0], sio_s} : {addr_r[22:0], sio_s[0]};
    assign addr_inc1_s = addr_r + 24'd1;
    assign addr_inc2_s = addr_r + 24'd2;
    assign addr_last_s = quad_r ? (cnt_r == 5'd5) : (cnt_r == 5'd23);
    assign data_last_s = quad_r ? (cnt_r == 5'd1) : (cnt_r == 5'd7);

    // Transaction FSM, memory read sequencing and registered pin outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            quad_r      <= 1'b0;
            cont_mode_r <= 1'b0;
            cnt_r       <= 5'd0;
            cmd_r       <= 7'd0;
            mode_hi_r   <= 2'd0;
            addr_r      <= 24'd0;
            shift_r     <= 8'd0;
            pbuf_r      <= 8'd0;
            rd_seen_r   <= 1'b0;
            rd_tgt_r    <= 1'b0;
            SIO_O       <= 4'h0;
            SIO_OE      <= 4'h0;
            MEMCS       <= 1'b0;
            MEMADDR     <= '0;
        end else begin
            MEMCS     <= 1'b0;
            rd_seen_r <= MEMCS;
            if (cen_s) begin
                // Deselect aborts whatever was in progress; only cont_mode survives.
                state_r   <= ST_IDLE;
                SIO_OE    <= 4'h0;
                cnt_r     <= 5'd0;
                rd_seen_r <= 1'b0;
            end else begin
                if (rd_seen_r) begin
                    if (rd_tgt_r) begin
                        pbuf_r <= MEMRDATA;
                    end else begin
                        // First byte arrived: start prefetching the one after it.
                        shift_r  <= MEMRDATA;
                        MEMCS    <= 1'b1;
                        MEMADDR  <= addr_inc1_s[MEM_AW-1:0];
                        rd_tgt_r <= 1'b1;
                    end
                end
                case (state_r)
                    ST_IDLE: begin
                        cnt_r <= 5'd0;
                        if (cont_mode_r) begin
                            quad_r  <= 1'b1;
                            state_r <= ST_ADDR;
                        end else begin
                            state_r <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise_s) begin
                            cmd_r <= cmd_next_s[6:0];
                            if (cnt_r == 5'd7) begin
                                cnt_r <= 5'd0;
                                if (cmd_next_s == CMD_READ) begin
                                    quad_r  <= 1'b0;
                                    state_r <= ST_ADDR;
                                end else if (cmd_next_s == CMD_QIOR) begin
                                    quad_r  <= 1'b1;
                                    state_r <= ST_ADDR;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end else begin
                                cnt_r <= cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise_s) begin
                            addr_r <= addr_next_s;
                            if (addr_last_s) begin
                                cnt_r <= 5'd0;
                                if (quad_r) begin
                                    state_r <= ST_MODE;
                                end else begin
                                    MEMCS    <= 1'b1;
                                    MEMADDR  <= addr_next_s[MEM_AW-1:0];
                                    rd_tgt_r <= 1'b0;
                                    state_r  <= ST_DATA;
                                end
                            end else begin
                                cnt_r <= cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_MODE: begin
                        if (sck_rise_s) begin
                            mode_hi_r <= sio_s[1:0];
                            if (cnt_r == 5'd1) begin
                                cont_mode_r <= mode_is_cont(mode_hi_r);
                                MEMCS       <= 1'b1;
                                MEMADDR     <= addr_r[MEM_AW-1:0];
                                rd_tgt_r    <= 1'b0;
                                cnt_r       <= 5'd0;
                                state_r     <= ST_DUMMY;
                            end else begin
                                cnt_r <= cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        SIO_OE <= 4'h0;
                        if (sck_rise_s) begin
                            if (cnt_r == DUMMY_LAST) begin
                                cnt_r   <= 5'd0;
                                state_r <= ST_DATA;
                            end else begin
                                cnt_r <= cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_fall_s) begin
                            if (quad_r) begin
                                SIO_OE <= 4'hF;
                                SIO_O  <= cnt_r[0] ? shift_r[3:0] : shift_r[7:4];
                            end else begin
                                SIO_OE <= 4'b0010;
                                SIO_O  <= {2'b00, shift_r[~cnt_r[2:0]], 1'b0};
                            end
                            if (data_last_s) begin
                                // Byte finished: swap in the prefetch and fetch the next one.
                                cnt_r    <= 5'd0;
                                shift_r  <= pbuf_r;
                                addr_r   <= addr_inc1_s;
                                MEMCS    <= 1'b1;
                                MEMADDR  <= addr_inc2_s[MEM_AW-1:0];
                                rd_tgt_r <= 1'b1;
                            end else begin
                                cnt_r <= cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        SIO_OE <= 4'h0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        SIO_OE  <= 4'h0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Scoreboard bench for qspi_flash_responder: a host driver plays flash
// transactions, a reference model queues the expected SIO words, and a
// monitor compares them at every SCK rise where the responder drives.
module tb_qspi_flash_responder;

    localparam int DUMMY = 4;

    logic        HCLK;
    logic        HRESETn;
    logic        SCK_I;
    logic        CEN_I;
    logic [3:0]  SIO_I;
    logic [3:0]  SIO_O;
    logic [3:0]  SIO_OE;
    logic        MEMCS;
    logic [19:0] MEMADDR;
    logic [7:0]  MEMRDATA;

    typedef struct packed {
        logic [3:0] oe;
        logic [3:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    logic [19:0] memq[$];
    int          total;
    int          bad;
    bit          model_cont;

    qspi_flash_responder #(.MEM_AW(20), .DUMMY_CYC(DUMMY), .SYNC_STAGES(2)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .SCK_I    (SCK_I),
        .CEN_I    (CEN_I),
        .SIO_I    (SIO_I),
        .SIO_O    (SIO_O),
        .SIO_OE   (SIO_OE),
        .MEMCS    (MEMCS),
        .MEMADDR  (MEMADDR),
        .MEMRDATA (MEMRDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Flash contents: byte[a] = a[7:0] ^ 5Ah, registered read.
    always @(posedge HCLK) begin
        if (MEMCS) MEMRDATA <= MEMADDR[7:0] ^ 8'h5A;
    end

    // Record every memory read address.
    always @(negedge HCLK) begin
        if (MEMCS) memq.push_back(MEMADDR);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: whenever the responder drives at an SCK rise, pop and compare.
    always @(posedge SCK_I) begin
        if (HRESETn === 1'b1 && SIO_OE !== 4'h0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_drive", 32'(SIO_OE), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sio_oe", 32'(SIO_OE), 32'(e.oe));
                chk("sio_o", 32'(SIO_O & e.oe), 32'(e.dat & e.oe));
            end
        end
    end

    function automatic logic [7:0] ref_byte(input logic [23:0] a);
        logic [23:0] w;
        w = a & 24'h0F_FFFF;
        return w[7:0] ^ 8'h5A;
    endfunction

    task automatic sck_cyc(input logic [3:0] d);
        SIO_I = d;
        SCK_I = 1'b0;
        #50;
        SCK_I = 1'b1;
        #50;
    endtask

    task automatic end_txn();
        SCK_I = 1'b0;
        #50;
        CEN_I = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("oe_after_cen", 32'(SIO_OE), 32'h0);
        #200;
        @(negedge HCLK);
        chk("exp_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    // kind 0: READ 03h, 1: quad read EBh, 2: unsupported command.
    task automatic txn(input int kind, input logic [7:0] cmd, input bit send_cmd,
                       input logic [23:0] addr, input logic [7:0] mode,
                       input int nd, input bit rst_mid);
        exp_t e;
        logic [7:0] b;
        memq.delete();
        CEN_I = 1'b0;
        #50;
        if (send_cmd) begin
            for (int i = 7; i >= 0; i--) sck_cyc({3'b000, cmd[i]});
        end
        if (kind == 2) begin
            for (int i = 0; i < nd; i++) sck_cyc(4'($urandom_range(0, 15)));
            chk("ignore_oe", 32'(SIO_OE), 32'h0);
        end else begin
            if (kind == 0) begin
                for (int i = 23; i >= 0; i--) sck_cyc({3'b000, addr[i]});
            end else begin
                for (int n = 5; n >= 0; n--) sck_cyc(addr[n*4 +: 4]);
                sck_cyc(mode[7:4]);
                sck_cyc(mode[3:0]);
                model_cont = (mode[5:4] == 2'b10);
                for (int i = 0; i < DUMMY; i++) sck_cyc(4'h0);
            end
            for (int i = 0; i < nd; i++) begin
                if (kind == 0) begin
                    b = ref_byte(addr + 24'(i / 8));
                    e.oe  = 4'b0010;
                    e.dat = {2'b00, b[7 - (i % 8)], 1'b0};
                end else begin
                    b = ref_byte(addr + 24'(i / 2));
                    e.oe  = 4'hF;
                    e.dat = (i % 2 == 0) ? b[7:4] : b[3:0];
                end
                exp_q.push_back(e);
            end
            for (int i = 0; i < nd; i++) begin
                sck_cyc(kind == 0 ? 4'($urandom_range(0, 15)) : 4'h0);
            end
            if (rst_mid) begin
                #20;
                HRESETn = 1'b0;
                #1;
                chk("rst_oe", 32'(SIO_OE), 32'h0);
                chk("rst_memcs", 32'(MEMCS), 32'h0);
                #19;
                HRESETn = 1'b1;
                model_cont = 1'b0;
            end
        end
        end_txn();
        if (kind == 2) begin
            chk("ignore_memcs", 32'(memq.size()), 32'h0);
        end else begin
            chk("memcs_seen", 32'(memq.size() > 0), 32'h1);
            for (int j = 0; j < memq.size(); j++) begin
                chk("memaddr", 32'(memq[j]), 32'((addr + 24'(j)) & 24'h0F_FFFF));
            end
        end
    endtask

    initial begin
        logic [7:0]  c;
        logic [7:0]  m;
        logic [23:0] a;
        int          r;
        int          nd;
        total = 0;
        bad = 0;
        model_cont = 1'b0;
        HRESETn = 1'b0;
        SCK_I = 1'b0;
        CEN_I = 1'b1;
        SIO_I = 4'h0;
        #25;
        @(negedge HCLK);
        chk("reset_sio_o", 32'(SIO_O), 32'h0);
        chk("reset_sio_oe", 32'(SIO_OE), 32'h0);
        chk("reset_memcs", 32'(MEMCS), 32'h0);
        chk("reset_memaddr", 32'(MEMADDR), 32'h0);
        HRESETn = 1'b1;
        #40;
        @(negedge HCLK);

        // Directed cases.
        txn(0, 8'h03, 1'b1, 24'h000010, 8'h00, 32, 1'b0);
        txn(1, 8'hEB, 1'b1, 24'h000100, 8'h00, 4, 1'b0);
        txn(0, 8'h03, 1'b1, 24'h000020, 8'h00, 8, 1'b0);   // cont_mode must be clear
        txn(1, 8'hEB, 1'b1, 24'h000200, 8'hA0, 4, 1'b0);
        txn(1, 8'h00, 1'b0, 24'h000300, 8'hFF, 4, 1'b0);   // continuous, no command
        txn(0, 8'h03, 1'b1, 24'h000040, 8'h00, 8, 1'b0);   // cont_mode cleared by FFh
        txn(2, 8'h9F, 1'b1, 24'h000000, 8'h00, 32, 1'b0);
        txn(0, 8'h03, 1'b1, 24'h000050, 8'h00, 16, 1'b0);

        // Abort after 3 address bits, then a read across the wrap point.
        memq.delete();
        CEN_I = 1'b0;
        #50;
        for (int i = 7; i >= 0; i--) sck_cyc({3'b000, 8'h03 >> i} & 4'h1);
        for (int i = 0; i < 3; i++) sck_cyc(4'h1);
        end_txn();
        chk("abort_memcs", 32'(memq.size()), 32'h0);
        txn(0, 8'h03, 1'b1, 24'h0FFFFF, 8'h00, 16, 1'b0);

        // Reset during continuous quad data; next access must carry a command.
        txn(1, 8'hEB, 1'b1, 24'h000400, 8'hA5, 3, 1'b1);
        txn(1, 8'hEB, 1'b1, 24'h000500, 8'h00, 4, 1'b0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 20; k++) begin
            a  = 24'($urandom);
            m  = 8'($urandom);
            if ($urandom_range(0, 1) == 1) m[5:4] = 2'b10;
            r  = $urandom_range(0, 4);
            if (model_cont) begin
                nd = $urandom_range(1, 8);
                txn(1, 8'h00, 1'b0, a, m, nd, 1'b0);
            end else if (r <= 1) begin
                nd = $urandom_range(1, 32);
                txn(0, 8'h03, 1'b1, a, m, nd, 1'b0);
            end else if (r <= 3) begin
                nd = $urandom_range(1, 8);
                txn(1, 8'hEB, 1'b1, a, m, nd, 1'b0);
            end else begin
                do c = 8'($urandom); while (c == 8'h03 || c == 8'hEB);
                txn(2, c, 1'b1, a, m, $urandom_range(1, 24), 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
